// File: rtl/ahb_intc.sv
// AHB-Lite interrupt controller: level/edge sources, fixed lowest-index priority,
// claim/complete handshake through a single CLAIM register.
module ahb_intc #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32,
   parameter int NIRQ   = 8
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              hsel_i,
   input  logic              hwrite_i,
   input  logic              hready_i,
   input  logic [2:0]        hsize_i,
   input  logic [2:0]        hburst_i,
   input  logic [1:0]        htrans_i,
   input  logic [AWIDTH-1:0] haddr_i,
   input  logic [DWIDTH-1:0] hwdata_i,
   output logic              hreadyout_o,
   output logic              hresp_o,
   output logic [DWIDTH-1:0] hrdata_o,
   input  logic [NIRQ-1:0]   irq_i,
   output logic              irq_o
);

   typedef enum logic {IDLE, SERVICE} state_t;

   state_t            state;
   logic [NIRQ-1:0]   pending;
   logic [NIRQ-1:0]   enable;
   logic [NIRQ-1:0]   irq_type;
   logic [NIRQ-1:0]   irq_q;
   logic [NIRQ-1:0]   eligible;
   logic [NIRQ-1:0]   win;
   logic [4:0]        claim_id;
   logic [4:0]        isid;
   logic              vld_p1;
   logic              write_p1;
   logic [3:0]        addr_p1;
   logic              addr_ok;
   logic              claim_go;
   logic              complete;
   logic              unused_ok;

   assign hreadyout_o = 1'b1;
   assign hresp_o     = 1'b0;
   assign unused_ok   = ^{hsize_i, hburst_i, htrans_i[0], haddr_i, hwdata_i};

   assign addr_ok  = hsel_i && hready_i && htrans_i[1];
   assign eligible = pending & enable;
   // Isolate the lowest set bit: that source wins arbitration.
   assign win      = eligible & (~eligible + NIRQ'(1));

   always_comb begin
      claim_id = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (eligible[i]) claim_id = 5'(i + 1);
      end
   end

   assign claim_go = vld_p1 && !write_p1 && (addr_p1 == 4'hC) &&
                     (state == IDLE) && (claim_id != 5'd0);
   assign complete = vld_p1 && write_p1 && (addr_p1 == 4'hC) &&
                     (state == SERVICE) && (hwdata_i[4:0] == isid);

   always_comb begin
      hrdata_o = '0;
      if (vld_p1 && !write_p1 && !hreset) begin
         case (addr_p1)
            4'h0:    hrdata_o = DWIDTH'(pending);
            4'h4:    hrdata_o = DWIDTH'(enable);
            4'h8:    hrdata_o = DWIDTH'(irq_type);
            4'hC:    hrdata_o = (state == IDLE) ? DWIDTH'(claim_id) : DWIDTH'(isid);
            default: hrdata_o = '0;
         endcase
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state    <= IDLE;
         pending  <= '0;
         enable   <= '0;
         irq_type <= '0;
         irq_q    <= '0;
         isid     <= '0;
         vld_p1   <= 1'b0;
         write_p1 <= 1'b0;
         addr_p1  <= '0;
         irq_o    <= 1'b0;
      end else begin
         // Address phase -> data phase
         vld_p1 <= addr_ok;
         if (addr_ok) begin
            write_p1 <= hwrite_i;
            addr_p1  <= haddr_i[3:0];
         end

         irq_q <= irq_i;
         for (int i = 0; i < NIRQ; i++) begin
            if (!irq_type[i])
               pending[i] <= irq_i[i];
            else if (irq_i[i] && !irq_q[i])
               pending[i] <= 1'b1;
            else if (claim_go && win[i])
               pending[i] <= 1'b0;
         end

         if (vld_p1 && write_p1) begin
            case (addr_p1)
               4'h4:    enable   <= hwdata_i[NIRQ-1:0];
               4'h8:    irq_type <= hwdata_i[NIRQ-1:0];
               default: ;
            endcase
         end

         case (state)
            IDLE: begin
               if (claim_go) begin
                  isid  <= claim_id;
                  state <= SERVICE;
               end
            end
            SERVICE: begin
               if (complete) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         irq_o <= (state == IDLE) && (|eligible);
      end
   end

endmodule

// File: tb/tb_ahb_intc.sv
// Directed bench for ahb_intc: register access, priority, edge/level, claim/complete, reset.
module tb_ahb_intc;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel_i;
   logic        hwrite_i;
   logic        hready_i;
   logic [2:0]  hsize_i;
   logic [2:0]  hburst_i;
   logic [1:0]  htrans_i;
   logic [31:0] haddr_i;
   logic [31:0] hwdata_i;
   logic        hreadyout_o;
   logic        hresp_o;
   logic [31:0] hrdata_o;
   logic [7:0]  irq_i;
   logic        irq_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 hclk = ~hclk;

   ahb_intc #(.AWIDTH(32), .DWIDTH(32), .NIRQ(8)) dut (
      .hclk        (hclk),
      .hreset      (hreset),
      .hsel_i      (hsel_i),
      .hwrite_i    (hwrite_i),
      .hready_i    (hready_i),
      .hsize_i     (hsize_i),
      .hburst_i    (hburst_i),
      .htrans_i    (htrans_i),
      .haddr_i     (haddr_i),
      .hwdata_i    (hwdata_i),
      .hreadyout_o (hreadyout_o),
      .hresp_o     (hresp_o),
      .hrdata_o    (hrdata_o),
      .irq_i       (irq_i),
      .irq_o       (irq_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge hclk);
         #1;
      end
   endtask

   task automatic ahb_wr(input logic [3:0] a, input logic [31:0] d);
      hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b1; haddr_i = {28'h0, a};
      tick();
      hsel_i = 1'b0; htrans_i = 2'b00; hwrite_i = 1'b0; hwdata_i = d;
      tick();
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b0; haddr_i = {28'h0, a};
      tick();
      hsel_i = 1'b0; htrans_i = 2'b00;
      d = hrdata_o;
      chk(tag, d, exp);
      tick();
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      chk(tag, {31'b0, irq_o}, {31'b0, exp});
   endtask

   initial begin
      hreset = 1'b1; hsel_i = 1'b0; hwrite_i = 1'b0; hready_i = 1'b1;
      hsize_i = 3'b010; hburst_i = 3'b000; htrans_i = 2'b00;
      haddr_i = '0; hwdata_i = '0; irq_i = '0;

      // reset behaviour
      #1;
      chk("rst_hrdata", hrdata_o, 32'h0);
      chk("rst_hreadyout", {31'b0, hreadyout_o}, 32'h1);
      chk("rst_hresp", {31'b0, hresp_o}, 32'h0);
      tick(2);
      chk_irq("rst_irq", 1'b0);
      hreset = 1'b0;
      rd_chk("rst_enable", 4'h4, 32'h0);
      rd_chk("rst_pending", 4'h0, 32'h0);
      rd_chk("rst_type", 4'h8, 32'h0);

      // level source
      ahb_wr(4'h4, 32'h1);
      irq_i = 8'h01;
      tick();
      chk_irq("lvl_irq_1cyc", 1'b0);
      tick();
      chk_irq("lvl_irq_2cyc", 1'b1);
      rd_chk("lvl_claim", 4'hC, 32'h1);
      tick();
      chk_irq("lvl_irq_after_claim", 1'b0);
      ahb_wr(4'hC, 32'h1);
      chk_irq("lvl_irq_at_complete", 1'b0);
      tick();
      chk_irq("lvl_irq_reassert", 1'b1);

      // priority
      irq_i = 8'h24;
      ahb_wr(4'h4, 32'hFFFF_FFFF);
      rd_chk("pri_enable_upper0", 4'h4, 32'hFF);
      rd_chk("pri_claim3", 4'hC, 32'h3);
      irq_i = 8'h20;
      ahb_wr(4'hC, 32'h3);
      rd_chk("pri_claim6", 4'hC, 32'h6);
      irq_i = 8'h00;
      ahb_wr(4'hC, 32'h6);

      // edge latch
      ahb_wr(4'h4, 32'h2);
      ahb_wr(4'h8, 32'h2);
      irq_i = 8'h02;
      tick();
      irq_i = 8'h00;
      tick();
      chk_irq("edge_irq", 1'b1);
      rd_chk("edge_pending", 4'h0, 32'h2);
      rd_chk("edge_claim", 4'hC, 32'h2);
      rd_chk("edge_pending_cleared", 4'h0, 32'h0);
      irq_i = 8'h02;
      tick();
      irq_i = 8'h00;
      rd_chk("edge_pending_in_service", 4'h0, 32'h2);
      chk_irq("edge_irq_in_service", 1'b0);
      ahb_wr(4'hC, 32'h2);
      tick();
      chk_irq("edge_irq_after_complete", 1'b1);
      rd_chk("edge_claim2", 4'hC, 32'h2);
      ahb_wr(4'hC, 32'h2);

      // bad complete, then empty claim
      ahb_wr(4'h8, 32'h0);
      ahb_wr(4'h4, 32'h1);
      irq_i = 8'h01;
      tick(2);
      rd_chk("bad_claim1", 4'hC, 32'h1);
      ahb_wr(4'hC, 32'h2);
      rd_chk("bad_still_service", 4'hC, 32'h1);
      chk_irq("bad_irq_low", 1'b0);
      irq_i = 8'h00;
      ahb_wr(4'hC, 32'h1);
      rd_chk("empty_claim", 4'hC, 32'h0);
      tick();
      chk_irq("empty_irq_low", 1'b0);

      // masking and unmapped offsets
      ahb_wr(4'h4, 32'h0);
      irq_i = 8'h01;
      tick(2);
      rd_chk("mask_pending", 4'h0, 32'h1);
      rd_chk("unmapped_read", 4'h1, 32'h0);
      chk_irq("mask_irq_low", 1'b0);
      ahb_wr(4'h4, 32'h1);
      tick();
      chk_irq("mask_irq_enabled", 1'b1);
      ahb_wr(4'h5, 32'h0);
      rd_chk("unmapped_write_ignored", 4'h4, 32'h1);

      // reset mid-service
      ahb_wr(4'h8, 32'h80);
      rd_chk("rstsvc_claim", 4'hC, 32'h1);
      irq_i = 8'h00;
      hreset = 1'b1;
      tick();
      hreset = 1'b0;
      chk_irq("rstsvc_irq", 1'b0);
      rd_chk("rstsvc_enable", 4'h4, 32'h0);
      rd_chk("rstsvc_pending", 4'h0, 32'h0);
      rd_chk("rstsvc_type", 4'h8, 32'h0);
      rd_chk("rstsvc_claim_empty", 4'hC, 32'h0);
      ahb_wr(4'h4, 32'h1);
      irq_i = 8'h01;
      tick(2);
      chk_irq("rstsvc_idle_irq", 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
